// File: rtl/axi_conv_pkg.sv
// Shared encodings for the AXI4-burst to AXI-Lite converter.
// Holds burst/response encodings, the converter FSM state type and a response-merge helper.
// No logic state lives here; consumers import it with axi_conv_pkg::*.
package axi_conv_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'd0,
    BURST_INCR  = 2'd1,
    BURST_WRAP  = 2'd2,
    BURST_RSVD  = 2'd3
  } burst_e;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'd0,
    RESP_EXOKAY = 2'd1,
    RESP_SLVERR = 2'd2,
    RESP_DECERR = 2'd3
  } resp_e;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR_ADDR = 3'd3,
    WR_DATA = 3'd4,
    WR_RESP = 3'd5,
    B_SEND  = 3'd6
  } state_e;

  // The numeric encoding already orders severity: DECERR > SLVERR > OKAY.
  function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Next-beat address for an AXI burst (FIXED / INCR / WRAP; reserved type behaves as INCR).
// Purely combinational, zero latency.
// No handshake; next_addr equals addr whenever step is low.
module axi_burst_addr_gen
  import axi_conv_pkg::*;
#(
  parameter int C_AXI_ADDR_WIDTH = 32
) (
  input  logic [C_AXI_ADDR_WIDTH-1:0] addr,
  input  logic [2:0]                  size,
  input  logic [7:0]                  len,
  input  logic [1:0]                  burst,
  input  logic                        step,
  output logic [C_AXI_ADDR_WIDTH-1:0] next_addr
);

  localparam int AW = C_AXI_ADDR_WIDTH;

  logic [AW-1:0] incr;
  logic [AW-1:0] span;
  logic [AW-1:0] wrap_mask;
  logic [AW-1:0] sum;

  // Wrap block is (len+1) * 2^size bytes; legal wrap lengths make it a power of two.
  always_comb begin
    incr      = AW'(1) << size;
    span      = (AW'(len) + AW'(1)) << size;
    wrap_mask = span - AW'(1);
    sum       = addr + incr;
    next_addr = addr;
    if (step) begin
      case (burst)
        BURST_FIXED: next_addr = addr;
        BURST_WRAP:  next_addr = (addr & ~wrap_mask) | (sum & wrap_mask);
        default:     next_addr = sum;
      endcase
    end
  end

endmodule

// File: rtl/axi_burst_lite_conv.sv
// Splits each AXI4 burst into LEN+1 single-beat AXI-Lite transactions, one burst in flight.
// Latency: M-side AR/AW one cycle after S-side grant; R/W data passed through combinationally.
// Backpressure: S_RREADY/M_WREADY forwarded straight through; B held until S_BREADY.
module axi_burst_lite_conv
  import axi_conv_pkg::*;
#(
  parameter int C_AXI_ID_WIDTH   = 12,
  parameter int C_AXI_ADDR_WIDTH = 32,
  parameter int C_AXI_DATA_WIDTH = 32
) (
  input  logic                          ACLK,
  input  logic                          ARESETN,
  input  logic [C_AXI_ID_WIDTH-1:0]     S_AXI_AWID,
  input  logic [C_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [7:0]                    S_AXI_AWLEN,
  input  logic [2:0]                    S_AXI_AWSIZE,
  input  logic [1:0]                    S_AXI_AWBURST,
  input  logic                          S_AXI_AWVALID,
  output logic                          S_AXI_AWREADY,
  input  logic [C_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                          S_AXI_WLAST,
  input  logic                          S_AXI_WVALID,
  output logic                          S_AXI_WREADY,
  output logic [C_AXI_ID_WIDTH-1:0]     S_AXI_BID,
  output logic [1:0]                    S_AXI_BRESP,
  output logic                          S_AXI_BVALID,
  input  logic                          S_AXI_BREADY,
  input  logic [C_AXI_ID_WIDTH-1:0]     S_AXI_ARID,
  input  logic [C_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [7:0]                    S_AXI_ARLEN,
  input  logic [2:0]                    S_AXI_ARSIZE,
  input  logic [1:0]                    S_AXI_ARBURST,
  input  logic                          S_AXI_ARVALID,
  output logic                          S_AXI_ARREADY,
  output logic [C_AXI_ID_WIDTH-1:0]     S_AXI_RID,
  output logic [C_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                    S_AXI_RRESP,
  output logic                          S_AXI_RLAST,
  output logic                          S_AXI_RVALID,
  input  logic                          S_AXI_RREADY,
  output logic [C_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic                          M_AXI_AWVALID,
  input  logic                          M_AXI_AWREADY,
  output logic [C_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                          M_AXI_WVALID,
  input  logic                          M_AXI_WREADY,
  input  logic [1:0]                    M_AXI_BRESP,
  input  logic                          M_AXI_BVALID,
  output logic                          M_AXI_BREADY,
  output logic [C_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic                          M_AXI_ARVALID,
  input  logic                          M_AXI_ARREADY,
  input  logic [C_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                    M_AXI_RRESP,
  input  logic                          M_AXI_RVALID,
  output logic                          M_AXI_RREADY
);

  localparam int IDW = C_AXI_ID_WIDTH;
  localparam int AW  = C_AXI_ADDR_WIDTH;

  state_e          state_q, state_d;
  logic            last_wr_q, last_wr_d;
  logic            rst_done_q;
  logic [IDW-1:0]  id_q, id_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [7:0]      len_q, len_d;
  logic [2:0]      size_q, size_d;
  logic [1:0]      burst_q, burst_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [1:0]      resp_q, resp_d;
  logic [AW-1:0]   next_addr;
  logic            out_en;
  logic            last_beat;
  logic            step;
  logic            grant_rd, grant_wr;
  logic            unused_wlast;

  // Burst length comes from LEN alone; WLAST carries no extra information here.
  assign unused_wlast = S_AXI_WLAST;

  // Handshakes stay masked during reset and for the first cycle after release.
  assign out_en    = ARESETN & rst_done_q;
  assign last_beat = (cnt_q == len_q);
  assign step      = out_en & ~last_beat &
                     (((state_q == RD_DATA) & M_AXI_RVALID & S_AXI_RREADY) |
                      ((state_q == WR_RESP) & M_AXI_BVALID));

  axi_burst_addr_gen #(.C_AXI_ADDR_WIDTH(AW)) u_addr_gen (
    .addr      (addr_q),
    .size      (size_q),
    .len       (len_q),
    .burst     (burst_q),
    .step      (step),
    .next_addr (next_addr)
  );

  // State, capture registers and the post-reset enable; synchronous active-low reset.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state_q    <= IDLE;
      last_wr_q  <= 1'b1;
      rst_done_q <= 1'b0;
      id_q       <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      size_q     <= '0;
      burst_q    <= '0;
      cnt_q      <= '0;
      resp_q     <= RESP_OKAY;
    end else begin
      state_q    <= state_d;
      last_wr_q  <= last_wr_d;
      rst_done_q <= 1'b1;
      id_q       <= id_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      size_q     <= size_d;
      burst_q    <= burst_d;
      cnt_q      <= cnt_d;
      resp_q     <= resp_d;
    end
  end

  // Next-state and handshake decode; every valid/ready stays low unless its state owns it.
  always_comb begin
    state_d       = state_q;
    last_wr_d     = last_wr_q;
    id_d          = id_q;
    addr_d        = addr_q;
    len_d         = len_q;
    size_d        = size_q;
    burst_d       = burst_q;
    cnt_d         = cnt_q;
    resp_d        = resp_q;
    grant_rd      = 1'b0;
    grant_wr      = 1'b0;
    S_AXI_AWREADY = 1'b0;
    S_AXI_WREADY  = 1'b0;
    S_AXI_BVALID  = 1'b0;
    S_AXI_ARREADY = 1'b0;
    S_AXI_RVALID  = 1'b0;
    S_AXI_RLAST   = 1'b0;
    M_AXI_AWVALID = 1'b0;
    M_AXI_WVALID  = 1'b0;
    M_AXI_BREADY  = 1'b0;
    M_AXI_ARVALID = 1'b0;
    M_AXI_RREADY  = 1'b0;
    S_AXI_BID     = id_q;
    S_AXI_BRESP   = resp_q;
    S_AXI_RID     = id_q;
    S_AXI_RDATA   = M_AXI_RDATA;
    S_AXI_RRESP   = M_AXI_RRESP;
    M_AXI_AWADDR  = addr_q;
    M_AXI_ARADDR  = addr_q;
    M_AXI_WDATA   = S_AXI_WDATA;
    M_AXI_WSTRB   = S_AXI_WSTRB;
    if (out_en) begin
      case (state_q)
        IDLE: begin
          // On contention the side that did not win last time goes first.
          grant_rd = S_AXI_ARVALID & (~S_AXI_AWVALID | last_wr_q);
          grant_wr = S_AXI_AWVALID & ~grant_rd;
          cnt_d    = '0;
          resp_d   = RESP_OKAY;
          if (grant_rd) begin
            S_AXI_ARREADY = 1'b1;
            last_wr_d     = 1'b0;
            id_d          = S_AXI_ARID;
            addr_d        = S_AXI_ARADDR;
            len_d         = S_AXI_ARLEN;
            size_d        = S_AXI_ARSIZE;
            burst_d       = S_AXI_ARBURST;
            state_d       = RD_ADDR;
          end else if (grant_wr) begin
            S_AXI_AWREADY = 1'b1;
            last_wr_d     = 1'b1;
            id_d          = S_AXI_AWID;
            addr_d        = S_AXI_AWADDR;
            len_d         = S_AXI_AWLEN;
            size_d        = S_AXI_AWSIZE;
            burst_d       = S_AXI_AWBURST;
            state_d       = WR_ADDR;
          end
        end
        RD_ADDR: begin
          M_AXI_ARVALID = 1'b1;
          if (M_AXI_ARREADY) state_d = RD_DATA;
        end
        RD_DATA: begin
          S_AXI_RVALID = M_AXI_RVALID;
          M_AXI_RREADY = S_AXI_RREADY;
          S_AXI_RLAST  = last_beat;
          if (M_AXI_RVALID && S_AXI_RREADY) begin
            cnt_d = cnt_q + 8'd1;
            if (last_beat) begin
              state_d = IDLE;
            end else begin
              addr_d  = next_addr;
              state_d = RD_ADDR;
            end
          end
        end
        WR_ADDR: begin
          M_AXI_AWVALID = 1'b1;
          if (M_AXI_AWREADY) state_d = WR_DATA;
        end
        WR_DATA: begin
          M_AXI_WVALID = S_AXI_WVALID;
          S_AXI_WREADY = M_AXI_WREADY;
          if (S_AXI_WVALID && M_AXI_WREADY) state_d = WR_RESP;
        end
        WR_RESP: begin
          M_AXI_BREADY = 1'b1;
          if (M_AXI_BVALID) begin
            resp_d = resp_max(resp_q, M_AXI_BRESP);
            cnt_d  = cnt_q + 8'd1;
            if (last_beat) begin
              state_d = B_SEND;
            end else begin
              addr_d  = next_addr;
              state_d = WR_ADDR;
            end
          end
        end
        B_SEND: begin
          S_AXI_BVALID = 1'b1;
          if (S_AXI_BREADY) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: doc/axi_burst_lite_conv.md
AXI_BURST_LITE_CONV -- requirements
Module: axi_burst_lite_conv

Interface
REQ-001 SHALL have parameter C_AXI_ID_WIDTH, default 12, ID width of the slave-side ID fields.
REQ-002 SHALL have parameter C_AXI_ADDR_WIDTH, default 32, address width on both sides.
REQ-003 SHALL have parameter C_AXI_DATA_WIDTH, default 32, data width on both sides; legal values are 32 and 64.
REQ-004 SHALL have the following ports, in this order:
- ACLK  in  1  clock; all logic is on the rising edge.
- ARESETN  in  1  reset, synchronous, active-low.
- S_AXI_AW{ID,ADDR,LEN[8],SIZE[3],BURST[2],VALID} in; S_AXI_AWREADY out.
- S_AXI_W{DATA,STRB,LAST,VALID} in; S_AXI_WREADY out.
- S_AXI_B{ID,RESP[2],VALID} out; S_AXI_BREADY in.
- S_AXI_AR{ID,ADDR,LEN[8],SIZE[3],BURST[2],VALID} in; S_AXI_ARREADY out.
- S_AXI_R{ID,DATA,RESP[2],LAST,VALID} out; S_AXI_RREADY in.
- M_AXI_AW{ADDR,VALID} out; M_AXI_AWREADY in.
- M_AXI_W{DATA,STRB,VALID} out; M_AXI_WREADY in.
- M_AXI_B{RESP,VALID} in; M_AXI_BREADY out.
- M_AXI_AR{ADDR,VALID} out; M_AXI_ARREADY in.
- M_AXI_R{DATA,RESP,VALID} in; M_AXI_RREADY out.

Function
REQ-005 SHALL convert each AXI4 burst on the S side into LEN+1 single-beat AXI-Lite transactions on the M side, with exactly one burst in flight.
REQ-006 SHALL use FSM states IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA, WR_RESP, B_SEND.
REQ-007 In IDLE, SHALL grant round-robin when ARVALID and AWVALID are both high; the winner is the opposite of the last grant, and the last-grant register resets to write so that read wins first.
REQ-008 Grant SHALL be signalled by S_*READY high for exactly one cycle in IDLE; the FSM captures ID, ADDR, LEN, SIZE and BURST, and AR/AWREADY are 0 in every other state.
REQ-009 Beat address SHALL follow the burst type:
- FIXED: constant.
- INCR: add 2^SIZE per beat, at full ADDR width, no 4 KB check.
- WRAP: add 2^SIZE, wrapping within an aligned block of (LEN+1)*2^SIZE bytes.
- Reserved burst type (3): treated as INCR.
REQ-010 Read path: RD_ADDR drives M_ARVALID, registered, first assertion one cycle after the S AR handshake, held until M_ARREADY; RD_DATA passes M_R to S_R combinationally (M_RREADY = S_RREADY).
REQ-011 In RD_DATA, S_RID SHALL be the captured ID; S_RLAST = 1 when beat count == LEN. RD_DATA exits to RD_ADDR, or to IDLE after the last beat.
REQ-012 Write path: WR_ADDR drives M_AWVALID. WR_DATA forwards one S W beat (M_WVALID = S_WVALID, S_WREADY = M_WREADY) only after the AW handshake for that beat completes. WR_RESP sets M_BREADY = 1.
REQ-013 S_WLAST SHALL be ignored; the beat count alone ends the burst.
REQ-014 BRESP SHALL be accumulated across beats as the maximum value (DECERR > SLVERR > OKAY) and returned once in B_SEND with the captured BID; B_SEND holds S_BVALID until S_BREADY, then goes to IDLE.
REQ-015 Beat counter SHALL be 8 bits, clear on grant, and increment on each M R handshake or M B handshake; LEN = 0 yields exactly one beat.
REQ-016 Outside the matching states, all M_*VALID, M_*READY, S_*VALID and S_*READY SHALL be 0.

Reset
REQ-017 While ARESETN = 0, and for one cycle after it rises, all VALID/READY outputs SHALL be 0.
REQ-018 Reset SHALL place the FSM in IDLE, clear the counter, the accumulated response and BID/RID, and set the last grant to write.
REQ-019 Reset mid-burst SHALL abandon the burst with no S_R or S_B response generated.

Structure
REQ-020 Burst-type and response encodings, and the FSM state enum, SHALL live in the shared package axi_conv_pkg.
REQ-021 The beat-address generator SHALL be a sub-module, axi_burst_addr_gen (inputs addr, size, len, burst, step; output next_addr).

Verification
REQ-022 Read INCR: ARADDR 0x1000, LEN 3, SIZE 2 -> M_ARADDR 0x1000, 0x1004, 0x1008, 0x100C; RLAST only on the 4th beat; RID echoed.
REQ-023 Write WRAP: AWADDR 0x1008, LEN 3, SIZE 2 -> M_AWADDR 0x1008, 0x100C, 0x1000, 0x1004; one S_B.
REQ-024 Error aggregation: write LEN 2 with M_BRESP OKAY, SLVERR, OKAY -> S_BRESP = SLVERR once.
REQ-025 AR and AW asserted in the same cycle, for 3 consecutive pairs -> grants in the order read, write, read, write, read, write.
REQ-026 Backpressure: S_RREADY low for 5 cycles mid-burst -> data held stable, no beat lost; FIXED burst LEN 1 -> both beats at the same address.
REQ-027 ARESETN low during beat 2 of an 8-beat read -> all valids 0 next cycle; a following read then completes normally.
